conv_window_sequencer: RTL

//  Frame-level sequencer for the 15-entry layer line buffer and its address counters.

---
 rtl/conv_window_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// Frame sequencer: loads DEPTH pixels into the line buffer, then issues NUM_WIN window reads.
// Optional completed-frame counter enabled by defining CONV_SEQ_FRAME_CNT_EN.
module conv_window_sequencer #(
   parameter int unsigned DEPTH   = 15,
   parameter int unsigned WIN     = 3,
   parameter int unsigned NUM_WIN = DEPTH / WIN,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic       write_en_o,
   input  logic       out_ready_i,
   output logic       read_en_o,
   output logic       out_valid_o,
   output logic [2:0] win_idx_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] frame_cnt_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             out_valid_q;
   logic [2:0]       win_idx_q, win_idx_d;

   // Strobes are combinational so the address counters advance in the same cycle as the handshake.
   assign in_ready_o  = (state_q == StLoad);
   assign write_en_o  = in_ready_o & in_valid_i;
   assign read_en_o   = (state_q == StRun) & out_ready_i;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign out_valid_o = out_valid_q;
   assign win_idx_o   = win_idx_q;

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      win_idx_d = win_idx_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = StLoad;
         end
         StLoad: begin
            if (write_en_o) begin
               if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
                  wr_cnt_d = '0;
                  state_d  = StRun;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         StRun: begin
            if (read_en_o) begin
               win_idx_d = 3'(rd_cnt_q);
               if (rd_cnt_q == CNT_W'(NUM_WIN - 1)) begin
                  rd_cnt_d = '0;
                  state_d  = StDone;
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         win_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= read_en_o;
         win_idx_q   <= win_idx_d;
      end
   end

`ifdef CONV_SEQ_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_q <= 8'd0;
      end else if (state_q == StDone) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`else
   assign frame_cnt_o = 8'd0;
`endif

endmodule
